spk_out_encoder: RTL and testbench
==================================

# spk_out_encoder

Transmit-side counterpart of the node's spike input path. It takes per-neuron fire results from the soma update scan and turns each firing neuron into a SPIKE packet with packed (x, y, z) coordinates, without dividing neuron indices. It also dumps soma memory as a DATA…DATA_END packet train. The block sits between soma and router output and buffers packets in a small FIFO behind a valid/ready handshake.

## Interface
- NNW, 12, neuron index / config field width
- SW, 24, packet data width; three coordinate fields of SW/3 bits
- FTW, 3, packet type width
- FD, 2, log2 FIFO depth (4 entries)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- x_out, y_out, z_out  in  NNW each  output map dimensions, static while not IDLE, each ≥1
- scan_start  in  1  pulse; starts a neuron scan (IDLE only)
- scan_vld  in  1  one neuron result offered, raster order (x fastest, then y, then z)
- scan_fire  in  1  neuron fired
- scan_rdy  out  1  result accepted when scan_vld & scan_rdy
- dump_req  in  1  pulse; starts memory dump (IDLE only)
- dump_len  in  NNW  words to dump, sampled with dump_req
- dump_re  out  1  soma memory read enable
- dump_raddr  out  NNW  soma memory read address
- dump_rdata  in  SW  read data, valid exactly 1 cycle after dump_re
- spk_out_vld  out  1  packet valid (FIFO not empty)
- spk_out_rdy  in  1  downstream ready
- spk_out_data  out  SW  packet payload
- spk_out_type  out  FTW  packet type: SPIKE=000, DATA=001, DATA_END=010

## Operation
- FSM states: IDLE, SCAN, DUMP. Reset → IDLE.
- IDLE: scan_start → SCAN, clear x/y/z counters. Else dump_req with dump_len≥2 → DUMP, clear read address and issued count. dump_req with dump_len<2 is a no-op. scan_start has priority when both are asserted.
- scan_start and dump_req are ignored outside IDLE.
- SCAN: scan_rdy = !fifo_full.
  - On an accepted result with scan_fire=1, push {type=SPIKE, data={z[SW/3-1:0], y[SW/3-1:0], x[SW/3-1:0]}}. z occupies the MSB field and x the LSB field. Coordinates above the field width are truncated.
  - Every accepted result (fired or not) advances the counters: x+1; if x==x_out-1 then x=0 and y+1; if also y==y_out-1 then y=0 and z+1.
  - Accepting x_out-1, y_out-1, z_out-1 → IDLE on the next cycle.
- DUMP:
  - Issue dump_re with dump_raddr = 0,1,…,dump_len-1, one per cycle. A read is issued only when fifo_count + reads_in_flight < 2^FD.
  - Each returned word is pushed the cycle after its dump_re. Words 0..len-2 are typed DATA; word len-1 is typed DATA_END.
  - After the last word is pushed → IDLE.
- FIFO: 2^FD entries of SW+FTW bits. Push and pop in the same cycle are both honoured. Pop happens on spk_out_vld & spk_out_rdy. The head drives spk_out_data and spk_out_type directly.
- scan_rdy = 0 in IDLE and DUMP.
- dump_re = 0 outside DUMP.
- Counter and address arithmetic is NNW-bit unsigned; with the sizes above, no wrap occurs.

## Timing
- Reset values: spk_out_vld=0, spk_out_data=0, spk_out_type=0, scan_rdy=0, dump_re=0, dump_raddr=0. FIFO is empty and the FSM is in IDLE.
- Asserting reset mid-scan or mid-dump discards FIFO contents and in-flight reads immediately.
- scan_start at cycle t → scan_rdy may be 1 from t+1.
- Firing result accepted at t → spk_out_vld=1 at t+1 if the FIFO was empty.
- dump_re at t → word pushed at end of t+1 → visible at output at t+2.
- When full, scan_rdy=0 even if a pop occurs in the same cycle (conservative).
- spk_out_data and spk_out_type stay stable while spk_out_vld=1 and spk_out_rdy=0.
- The DUMP→IDLE transition requires the final DATA_END to have been pushed, not popped. The FIFO keeps draining afterwards.

## Test plan
- Scan with x_out=3, y_out=2, z_out=1, fire on index 4, spk_out_rdy=1.
  - Expect one SPIKE, data=0x000101 (z=0, y=1, x=1). FSM returns to IDLE after the 6th accept.
- Scan with z_out=2, x_out=y_out=2, all 8 neurons fire, spk_out_rdy held 0.
  - scan_rdy drops after 4 accepts.
  - Releasing rdy drains packets in order; the last is data=0x010101.
- dump_len=3, memory returns 0xA0000 + addr.
  - Expect DATA 0x0A0000, DATA 0x0A0001, DATA_END 0x0A0002.
  - dump_raddr sequence 0,1,2; FSM is in IDLE afterwards.
- dump_len=6 with spk_out_rdy toggling every cycle.
  - No FIFO overflow; dump_re is throttled; all 6 words arrive in order; only the last is DATA_END.
- dump_req with dump_len=1, then scan_start during SCAN, then dump_req during SCAN.
  - All are ignored: no packets and no state change.
- Assert rst_n low mid-dump with 2 entries in the FIFO.
  - spk_out_vld=0 immediately, FSM in IDLE, dump_re=0.

Source files
------------

// File: rtl/spk_out_encoder.sv
// Spike/data packet encoder: turns soma scan fire results into SPIKE packets with
// raster (x,y,z) coordinates and streams soma memory dumps as DATA..DATA_END trains.
package spk_out_encoder_pkg;
    localparam int unsigned NNW   = 12;
    localparam int unsigned SW    = 24;
    localparam int unsigned FTW   = 3;
    localparam int unsigned FD    = 2;
    localparam int unsigned CW    = SW / 3;
    localparam int unsigned DEPTH = 1 << FD;

    typedef enum logic [FTW-1:0] {
        PKT_SPIKE    = 3'b000,
        PKT_DATA     = 3'b001,
        PKT_DATA_END = 3'b010
    } pkt_type_e;

    typedef struct packed {
        pkt_type_e       ptype;
        logic [SW-1:0]   data;
    } pkt_t;
endpackage

module spk_out_encoder
    import spk_out_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NNW-1:0]  i_x_out,
    input  logic [NNW-1:0]  i_y_out,
    input  logic [NNW-1:0]  i_z_out,
    input  logic            i_scan_start,
    input  logic            i_scan_vld,
    input  logic            i_scan_fire,
    output logic            o_scan_rdy,
    input  logic            i_dump_req,
    input  logic [NNW-1:0]  i_dump_len,
    output logic            o_dump_re,
    output logic [NNW-1:0]  o_dump_raddr,
    input  logic [SW-1:0]   i_dump_rdata,
    output logic            o_spk_out_vld,
    input  logic            i_spk_out_rdy,
    output logic [SW-1:0]   o_spk_out_data,
    output logic [FTW-1:0]  o_spk_out_type
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DUMP = 2'd2
    } state_e;

    state_e          r_state, w_state_d;
    logic [NNW-1:0]  r_x, r_y, r_z, w_x_d, w_y_d, w_z_d;
    logic [NNW-1:0]  r_len, r_issued, r_rcv, w_len_d, w_issued_d, w_rcv_d;
    logic            r_scan_rdy, r_dump_re, r_rd_pend, r_vld;
    logic            w_scan_rdy_d, w_dump_re_d, w_rd_pend_d, w_vld_d;
    logic [FD-1:0]   r_wptr, r_rptr;
    logic [FD:0]     r_count, w_count_d;
    pkt_t            r_mem [DEPTH];
    pkt_t            w_push_pkt, w_head;
    logic            w_push, w_pop, w_accept;
    logic            w_x_last, w_y_last, w_z_last, w_rcv_last;

    assign w_x_last   = (r_x == i_x_out - NNW'(1));
    assign w_y_last   = (r_y == i_y_out - NNW'(1));
    assign w_z_last   = (r_z == i_z_out - NNW'(1));
    assign w_rcv_last = (r_rcv == r_len - NNW'(1));

    // Next-state, counters, FIFO push selection and next values of the registered outputs
    always_comb begin
        w_state_d   = r_state;
        w_x_d       = r_x;
        w_y_d       = r_y;
        w_z_d       = r_z;
        w_len_d     = r_len;
        w_issued_d  = r_issued + NNW'(r_dump_re);
        w_rcv_d     = r_rcv;
        w_rd_pend_d = r_dump_re;
        w_push      = 1'b0;
        w_push_pkt  = '0;
        w_accept    = (r_state == ST_SCAN) && i_scan_vld && r_scan_rdy;
        w_pop       = r_vld && i_spk_out_rdy;

        case (r_state)
            ST_IDLE: begin
                if (i_scan_start) begin
                    w_state_d = ST_SCAN;
                    w_x_d     = '0;
                    w_y_d     = '0;
                    w_z_d     = '0;
                end else if (i_dump_req && (i_dump_len >= NNW'(2))) begin
                    w_state_d  = ST_DUMP;
                    w_len_d    = i_dump_len;
                    w_issued_d = '0;
                    w_rcv_d    = '0;
                end
            end
            ST_SCAN: begin
                if (w_accept) begin
                    if (i_scan_fire) begin
                        w_push           = 1'b1;
                        w_push_pkt.ptype = PKT_SPIKE;
                        w_push_pkt.data  = {r_z[CW-1:0], r_y[CW-1:0], r_x[CW-1:0]};
                    end
                    if (w_x_last) begin
                        w_x_d = '0;
                        if (w_y_last) begin
                            w_y_d = '0;
                            w_z_d = r_z + NNW'(1);
                            if (w_z_last) begin
                                w_state_d = ST_IDLE;
                            end
                        end else begin
                            w_y_d = r_y + NNW'(1);
                        end
                    end else begin
                        w_x_d = r_x + NNW'(1);
                    end
                end
            end
            ST_DUMP: begin
                if (r_rd_pend) begin
                    w_push           = 1'b1;
                    w_push_pkt.data  = i_dump_rdata;
                    w_push_pkt.ptype = w_rcv_last ? PKT_DATA_END : PKT_DATA;
                    w_rcv_d          = r_rcv + NNW'(1);
                    if (w_rcv_last) begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_count_d    = r_count + (FD+1)'(w_push) - (FD+1)'(w_pop);
        w_vld_d      = (w_count_d != '0);
        w_scan_rdy_d = (w_state_d == ST_SCAN) && (w_count_d != (FD+1)'(DEPTH));
        // A read may only issue if the FIFO can absorb it plus the word already returning
        w_dump_re_d  = (w_state_d == ST_DUMP) && (w_issued_d < w_len_d) &&
                       ((w_count_d + (FD+1)'(w_rd_pend_d)) < (FD+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_rcv      <= '0;
            r_scan_rdy <= 1'b0;
            r_dump_re  <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_vld      <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_x        <= w_x_d;
            r_y        <= w_y_d;
            r_z        <= w_z_d;
            r_len      <= w_len_d;
            r_issued   <= w_issued_d;
            r_rcv      <= w_rcv_d;
            r_scan_rdy <= w_scan_rdy_d;
            r_dump_re  <= w_dump_re_d;
            r_rd_pend  <= w_rd_pend_d;
            r_vld      <= w_vld_d;
            r_count    <= w_count_d;
            r_wptr     <= r_wptr + FD'(w_push);
            r_rptr     <= r_rptr + FD'(w_pop);
        end
    end

    // FIFO storage; the head entry drives the packet outputs directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_push_pkt;
        end
    end

    assign w_head         = r_mem[r_rptr];
    assign o_spk_out_vld  = r_vld;
    assign o_spk_out_data = w_head.data;
    assign o_spk_out_type = w_head.ptype;
    assign o_scan_rdy     = r_scan_rdy;
    assign o_dump_re      = r_dump_re;
    assign o_dump_raddr   = r_issued;

endmodule

// File: tb/tb_spk_out_encoder.sv
// Randomized bench for spk_out_encoder: a monitor predicts every packet from the
// accepted scan results (coordinates by div/mod) and issued dump reads.
module tb_spk_out_encoder;
    import spk_out_encoder_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [11:0]    i_x_out = 12'd1, i_y_out = 12'd1, i_z_out = 12'd1;
    logic           i_scan_start = 1'b0, i_scan_vld = 1'b0, i_scan_fire = 1'b0;
    logic           i_dump_req = 1'b0;
    logic [11:0]    i_dump_len = '0;
    logic [23:0]    i_dump_rdata;
    logic           i_spk_out_rdy;
    logic           o_scan_rdy, o_dump_re, o_spk_out_vld;
    logic [11:0]    o_dump_raddr;
    logic [23:0]    o_spk_out_data;
    logic [2:0]     o_spk_out_type;

    always #5 clk = ~clk;

    spk_out_encoder u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_x_out        (i_x_out),
        .i_y_out        (i_y_out),
        .i_z_out        (i_z_out),
        .i_scan_start   (i_scan_start),
        .i_scan_vld     (i_scan_vld),
        .i_scan_fire    (i_scan_fire),
        .o_scan_rdy     (o_scan_rdy),
        .i_dump_req     (i_dump_req),
        .i_dump_len     (i_dump_len),
        .o_dump_re      (o_dump_re),
        .o_dump_raddr   (o_dump_raddr),
        .i_dump_rdata   (i_dump_rdata),
        .o_spk_out_vld  (o_spk_out_vld),
        .i_spk_out_rdy  (i_spk_out_rdy),
        .o_spk_out_data (o_spk_out_data),
        .o_spk_out_type (o_spk_out_type)
    );

    int          n_total = 0;
    int          n_bad = 0;
    pkt_t        exp_q[$];
    int          acc_cnt = 0, scan_base = 0;
    int          re_cnt = 0, dump_base = 0;
    int          pop_cnt = 0;
    logic [23:0] last_data = '0;
    logic [2:0]  last_type = '0;
    bit          dump_active = 1'b0;
    int          cfg_x = 1, cfg_y = 1, cfg_z = 1, cfg_len = 0;
    logic [23:0] mem_base = '0;
    int          rdy_mode = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] spike_of(input int idx);
        logic [7:0] xx, yy, zz;
        xx = 8'(idx % cfg_x);
        yy = 8'((idx / cfg_x) % cfg_y);
        zz = 8'(idx / (cfg_x * cfg_y));
        return {zz, yy, xx};
    endfunction

    // Synchronous soma memory: word at address a is mem_base + a
    always @(posedge clk) i_dump_rdata <= 24'(mem_base + 24'(o_dump_raddr));

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       i_spk_out_rdy = 1'b0;
            1:       i_spk_out_rdy = 1'b1;
            2:       i_spk_out_rdy = ~i_spk_out_rdy;
            default: i_spk_out_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: predicts packets at issue/accept time and checks them when popped
    bit          hold = 1'b0;
    logic [23:0] hold_data;
    logic [2:0]  hold_type;
    always @(negedge clk) begin : mon
        int   idx;
        pkt_t p;
        if (!rst_n) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_vld", 32'(o_spk_out_vld), 32'd1);
                chk("hold_data", 32'(o_spk_out_data), 32'(hold_data));
                chk("hold_type", 32'(o_spk_out_type), 32'(hold_type));
            end
            hold      = o_spk_out_vld && !i_spk_out_rdy;
            hold_data = o_spk_out_data;
            hold_type = o_spk_out_type;
            if (o_dump_re) begin
                idx = re_cnt - dump_base;
                chk("re_allowed", 32'(dump_active), 32'd1);
                chk("re_throttle", 32'(exp_q.size() < 4), 32'd1);
                chk("raddr", 32'(o_dump_raddr), 32'(idx));
                p.ptype = (idx == cfg_len - 1) ? PKT_DATA_END : PKT_DATA;
                p.data  = 24'(mem_base + 24'(idx));
                exp_q.push_back(p);
                re_cnt++;
            end
            if (o_scan_rdy && i_scan_vld) begin
                idx = acc_cnt - scan_base;
                chk("scan_in_range", 32'(idx < cfg_x * cfg_y * cfg_z), 32'd1);
                if (i_scan_fire) begin
                    p.ptype = PKT_SPIKE;
                    p.data  = spike_of(idx);
                    exp_q.push_back(p);
                end
                acc_cnt++;
            end
            if (o_spk_out_vld && i_spk_out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pkt", 32'd1, 32'd0);
                end else begin
                    p = exp_q.pop_front();
                    chk("pkt_type", 32'(o_spk_out_type), 32'(p.ptype));
                    chk("pkt_data", 32'(o_spk_out_data), 32'(p.data));
                end
                pop_cnt++;
                last_data = o_spk_out_data;
                last_type = o_spk_out_type;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        if (rdy_mode == 0) rdy_mode = 1;
        while ((exp_q.size() != 0 || o_spk_out_vld) && guard < 500) begin
            cyc(1);
            guard++;
        end
        chk("drain_timeout", 32'(guard < 500), 32'd1);
    endtask

    task automatic start_scan(input int x, input int y, input int z);
        cfg_x = x; cfg_y = y; cfg_z = z;
        i_x_out = 12'(x); i_y_out = 12'(y); i_z_out = 12'(z);
        scan_base    = acc_cnt;
        i_scan_start = 1'b1;
        cyc(1);
        i_scan_start = 1'b0;
    endtask

    // fmode: 0 random fire, 1 all fire, 2 only fire_idx; disturb pulses start/dump mid-scan
    task automatic scan_feed(input int fmode, input int fire_idx, input bit vld_rand, input bit disturb);
        int guard = 0;
        int idx;
        int total = cfg_x * cfg_y * cfg_z;
        while ((acc_cnt - scan_base) < total && guard < 2000) begin
            idx          = acc_cnt - scan_base;
            i_scan_vld   = vld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_scan_fire  = (fmode == 1) ? 1'b1 : (fmode == 2) ? (idx == fire_idx) : 1'($urandom_range(0, 1));
            i_scan_start = disturb && (guard == 2);
            i_dump_req   = disturb && (guard == 3);
            i_dump_len   = 12'd4;
            cyc(1);
            guard++;
        end
        i_scan_vld = 1'b0; i_scan_fire = 1'b0; i_scan_start = 1'b0; i_dump_req = 1'b0;
        chk("scan_timeout", 32'(guard < 2000), 32'd1);
        chk("scan_end_rdy", 32'(o_scan_rdy), 32'd0);
    endtask

    task automatic run_dump(input int len, input logic [23:0] base);
        int guard = 0;
        int pops0 = pop_cnt;
        mem_base    = base;
        cfg_len     = len;
        dump_base   = re_cnt;
        dump_active = 1'b1;
        i_dump_len  = 12'(len);
        i_dump_req  = 1'b1;
        cyc(1);
        i_dump_req  = 1'b0;
        while ((re_cnt - dump_base < len || exp_q.size() != 0 || o_spk_out_vld) && guard < 1000) begin
            cyc(1);
            guard++;
        end
        dump_active = 1'b0;
        chk("dump_timeout", 32'(guard < 1000), 32'd1);
        chk("dump_reads", 32'(re_cnt - dump_base), 32'(len));
        chk("dump_pops", 32'(pop_cnt - pops0), 32'(len));
        chk("dump_last_type", 32'(last_type), 32'(PKT_DATA_END));
        chk("dump_idle_re", 32'(o_dump_re), 32'd0);
    endtask

    initial begin
        int pops0;
        int re0;
        cyc(3);
        chk("rst_vld", 32'(o_spk_out_vld), 32'd0);
        chk("rst_data", 32'(o_spk_out_data), 32'd0);
        chk("rst_type", 32'(o_spk_out_type), 32'd0);
        chk("rst_scan_rdy", 32'(o_scan_rdy), 32'd0);
        chk("rst_dump_re", 32'(o_dump_re), 32'd0);
        chk("rst_raddr", 32'(o_dump_raddr), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // 3x2x1 map, only neuron 4 fires
        rdy_mode = 1;
        pops0 = pop_cnt;
        start_scan(3, 2, 1);
        chk("start_rdy", 32'(o_scan_rdy), 32'd1);
        scan_feed(2, 4, 1'b0, 1'b0);
        drain();
        chk("t1_pops", 32'(pop_cnt - pops0), 32'd1);
        chk("t1_data", 32'(last_data), 32'h000101);

        // 2x2x2 map, all fire, downstream stalled
        rdy_mode = 0;
        start_scan(2, 2, 2);
        i_scan_vld = 1'b1; i_scan_fire = 1'b1;
        cyc(10);
        i_scan_vld = 1'b0;
        chk("full_accepts", 32'(acc_cnt - scan_base), 32'd4);
        chk("full_rdy", 32'(o_scan_rdy), 32'd0);
        rdy_mode = 1;
        scan_feed(1, 0, 1'b0, 1'b0);
        drain();
        chk("t2_last", 32'(last_data), 32'h010101);

        // Short dump and throttled dump
        run_dump(3, 24'h0A0000);
        chk("t3_last_data", 32'(last_data), 32'h0A0002);
        rdy_mode = 2;
        run_dump(6, 24'h123400);
        rdy_mode = 1;

        // Ignored requests
        pops0 = pop_cnt; re0 = re_cnt;
        i_dump_len = 12'd1; i_dump_req = 1'b1;
        cyc(1);
        i_dump_req = 1'b0;
        cyc(6);
        chk("len1_reads", 32'(re_cnt - re0), 32'd0);
        chk("len1_pops", 32'(pop_cnt - pops0), 32'd0);
        start_scan(3, 2, 2);
        scan_feed(1, 0, 1'b0, 1'b1);
        drain();
        chk("disturb_reads", 32'(re_cnt - re0), 32'd0);

        // Reset in the middle of a dump
        rdy_mode = 0;
        mem_base = 24'h00BEEF; cfg_len = 6; dump_base = re_cnt; dump_active = 1'b1;
        i_dump_len = 12'd6; i_dump_req = 1'b1;
        cyc(1);
        i_dump_req = 1'b0;
        cyc(3);
        chk("pre_rst_vld", 32'(o_spk_out_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(o_spk_out_vld), 32'd0);
        chk("mid_rst_re", 32'(o_dump_re), 32'd0);
        chk("mid_rst_rdy", 32'(o_scan_rdy), 32'd0);
        cyc(2);
        dump_active = 1'b0;
        rst_n = 1'b1;
        rdy_mode = 1;
        cyc(5);
        chk("post_rst_vld", 32'(o_spk_out_vld), 32'd0);

        // Random mix of scans and dumps
        for (int it = 0; it < 10; it++) begin
            rdy_mode = 3;
            if ($urandom_range(0, 1) == 1) begin
                start_scan(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
                scan_feed(0, 0, 1'b1, 1'b0);
            end else begin
                run_dump(int'($urandom_range(2, 9)), 24'($urandom));
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
